// File: rtl/vga_timing_gen.sv
// Raster timing for 640x480@60: pixel/line counters, registered sync and blank decodes,
// and a short delay pipe that keeps the VGA-pin syncs aligned with downstream registered RGB.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        hs_d,
  output logic        vs_d,
  output logic        blank_d,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Sync is active low inside [beg, beg+len); integer compare avoids 10-bit overflow at 1024.
  function automatic logic sync_n(input logic [9:0] pos, input int beg, input int len);
    int p;
    p = int'(pos);
    return !((p >= beg) && (p < beg + len));
  endfunction

  function automatic logic visible(input logic [9:0] x, input logic [9:0] y);
    return (int'(x) < H_VISIBLE) && (int'(y) < V_VISIBLE);
  endfunction

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       x_wrap;
  logic       frame_wrap;

  always_comb begin
    x_wrap     = (DrawX == H_LAST);
    frame_wrap = x_wrap && (DrawY == V_LAST);
    x_next     = x_wrap ? 10'd0 : DrawX + 10'd1;
    y_next     = DrawY;
    if (x_wrap)
      y_next = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
  end

  // Stage p0: counters and decodes of the next position, so all outputs share one edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      DrawX       <= x_next;
      DrawY       <= y_next;
      hs          <= sync_n(x_next, H_VISIBLE + H_FP, H_SYNC);
      vs          <= sync_n(y_next, V_VISIBLE + V_FP, V_SYNC);
      blank       <= visible(x_next, y_next);
      frame_start <= frame_wrap;
      if (frame_wrap)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign hs_d    = hs;
      assign vs_d    = vs;
      assign blank_d = blank;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_p1;
      logic [PIPE_DLY-1:0] vs_p1;
      logic [PIPE_DLY-1:0] blank_p1;

      // Stage p1: shift registers; bit 0 is the newest sample.
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_p1    <= '1;
          vs_p1    <= '1;
          blank_p1 <= '0;
        end else begin
          hs_p1    <= PIPE_DLY'({hs_p1, hs});
          vs_p1    <= PIPE_DLY'({vs_p1, vs});
          blank_p1 <= PIPE_DLY'({blank_p1, blank});
        end
      end

      assign hs_d    = hs_p1[PIPE_DLY-1];
      assign vs_d    = vs_p1[PIPE_DLY-1];
      assign blank_d = blank_p1[PIPE_DLY-1];
    end
  endgenerate

endmodule
